flexka_presum_adder: RTL and testbench

Karatsuba pre-summation stage directly upstream of the base multiplier. It reads one stacked operand of `src_size` limbs from an input buffer and splits it into lo = limbs [0, h) and hi = limbs [h, n), where h = ceil(n/2). It writes the limb-wise sum lo + hi, plus a final carry limb, back onto the stack at `dst_pos`. The base multiplier then consumes that stacked result as a (h+1)-limb operand when it forms the middle Karatsuba product. One instance serves the A-side buffer and one serves the B-side buffer.

---
 rtl/flexka_presum_adder.sv | 196 +++++++++++++++++++
 tb/tb_flexka_presum_adder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flexka_presum_adder.sv
// Karatsuba pre-summation: writes lo + hi of one stacked operand (plus a carry limb) back onto the stack.
// wdata is combinational from rdata, so the buffer's rdata must come straight from a register.
module flexka_presum_adder #(
    parameter int unsigned FSIZE               = 32,
    parameter int unsigned IN_BUFFER_SIZE      = 256,
    parameter int unsigned BUFFER_READ_LATENCY = 2,
    localparam int unsigned AW                 = $clog2(IN_BUFFER_SIZE)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [AW-1:0]    src_pos,
    input  logic [AW-1:0]    src_size,
    input  logic [AW-1:0]    dst_pos,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    res_size,
    output logic             read_valid,
    output logic [AW-1:0]    raddr0,
    output logic [AW-1:0]    raddr1,
    input  logic [FSIZE-1:0] rdata0,
    input  logic [FSIZE-1:0] rdata1,
    output logic             wren,
    output logic [AW-1:0]    waddr,
    output logic [FSIZE-1:0] wdata
);

    localparam int unsigned L = BUFFER_READ_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_CARRY = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] idx;
    logic [AW-1:0] h_q;
    logic [AW-1:0] hl_q;
    logic [AW-1:0] dst_q;
    logic          carry;
    logic          carry_wr;

    // Tag pipeline; the last stage doubles as the write-port register.
    logic          pv [L];
    logic          pz [L];
    logic          pl [L];
    logic [AW-1:0] pa [L];

    logic [AW-1:0]  h_c;
    logic [AW-1:0]  hl_c;
    logic           accept_c;
    logic           issue_last_c;
    logic           last_ret_c;
    logic           carry_load_c;
    logic           finish_c;
    logic [FSIZE-1:0] hi_c;
    logic [FSIZE:0]   sum_c;

    // Address add modulo the buffer depth (depth need not be a power of two).
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (AW+1)'(IN_BUFFER_SIZE)) begin
            s = s - (AW+1)'(IN_BUFFER_SIZE);
        end
        return s[AW-1:0];
    endfunction

    assign h_c  = AW'(({1'b0, src_size} + (AW+1)'(1)) >> 1);
    assign hl_c = src_size >> 1;

    assign last_ret_c   = pv[L-1] && pl[L-1] && !carry_wr;
    assign issue_last_c = (state == S_ISSUE) && (idx == h_q - AW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start)        state_nx = S_ISSUE;
            S_ISSUE: if (issue_last_c) state_nx = S_DRAIN;
            S_DRAIN: if (last_ret_c)   state_nx = S_CARRY;
            S_CARRY:                   state_nx = S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        accept_c     = 1'b0;
        carry_load_c = 1'b0;
        finish_c     = 1'b0;
        case (state)
            S_IDLE:  accept_c     = start;
            S_DRAIN: carry_load_c = last_ret_c;
            S_CARRY: finish_c     = 1'b1;
            default: ;
        endcase
    end

    // Return-path sum; the missing hi limb of an odd operand reads as zero.
    always_comb begin
        hi_c  = pz[L-1] ? '0 : rdata1;
        sum_c = {1'b0, rdata0} + {1'b0, hi_c} + (FSIZE+1)'(carry);
        wdata = '0;
        if (pv[L-1]) begin
            wdata = carry_wr ? FSIZE'(carry) : sum_c[FSIZE-1:0];
        end
    end

    assign wren  = pv[L-1];
    assign waddr = pa[L-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            res_size   <= '0;
            read_valid <= 1'b0;
            raddr0     <= '0;
            raddr1     <= '0;
            idx        <= '0;
            h_q        <= '0;
            hl_q       <= '0;
            dst_q      <= '0;
            carry      <= 1'b0;
            carry_wr   <= 1'b0;
            for (int k = 0; k < L; k++) begin
                pv[k] <= 1'b0;
                pz[k] <= 1'b0;
                pl[k] <= 1'b0;
                pa[k] <= '0;
            end
        end else begin
            done     <= carry_load_c;
            carry_wr <= carry_load_c;

            if (pv[L-1] && !carry_wr) begin
                carry <= sum_c[FSIZE];
            end

            if (accept_c) begin
                h_q        <= h_c;
                hl_q       <= hl_c;
                dst_q      <= dst_pos;
                res_size   <= h_c + AW'(1);
                idx        <= '0;
                carry      <= 1'b0;
                busy       <= 1'b1;
                read_valid <= 1'b1;
                raddr0     <= src_pos;
                raddr1     <= wrap_add(src_pos, h_c);
            end else if (state == S_ISSUE) begin
                if (issue_last_c) begin
                    read_valid <= 1'b0;
                end else begin
                    idx    <= idx + AW'(1);
                    raddr0 <= wrap_add(raddr0, AW'(1));
                    raddr1 <= wrap_add(raddr1, AW'(1));
                end
            end

            if (finish_c) begin
                busy <= 1'b0;
            end

            pv[0] <= read_valid;
            pa[0] <= wrap_add(dst_q, idx);
            pz[0] <= (idx >= hl_q);
            pl[0] <= (idx == h_q - AW'(1));
            for (int k = 1; k < L; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
                pz[k] <= pz[k-1];
                pl[k] <= pl[k-1];
            end

            // Carry limb rides the write-port stage the cycle after the last sum.
            if (carry_load_c) begin
                pv[L-1] <= 1'b1;
                pa[L-1] <= wrap_add(dst_q, h_q);
                pz[L-1] <= 1'b0;
                pl[L-1] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flexka_presum_adder.sv
// Scoreboard bench for flexka_presum_adder with a 2-cycle registered buffer model.
module tb_flexka_presum_adder;

    localparam int unsigned FS  = 32;
    localparam int unsigned BS  = 256;
    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 8;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] src_pos;
    logic [AW-1:0] src_size;
    logic [AW-1:0] dst_pos;
    logic          busy;
    logic          done;
    logic [AW-1:0] res_size;
    logic          read_valid;
    logic [AW-1:0] raddr0;
    logic [AW-1:0] raddr1;
    logic [FS-1:0] rdata0;
    logic [FS-1:0] rdata1;
    logic          wren;
    logic [AW-1:0] waddr;
    logic [FS-1:0] wdata;

    flexka_presum_adder #(
        .FSIZE(FS), .IN_BUFFER_SIZE(BS), .BUFFER_READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .src_pos(src_pos), .src_size(src_size), .dst_pos(dst_pos),
        .busy(busy), .done(done), .res_size(res_size),
        .read_valid(read_valid), .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1),
        .wren(wren), .waddr(waddr), .wdata(wdata)
    );

    typedef struct { int addr; logic [31:0] data; int cyc; bit dn; } wr_t;
    typedef struct { int a0; int a1; int cyc; } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    logic [31:0] mem [BS];
    logic [AW-1:0] a0_d, a1_d;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  edge_cnt = 0;
    int  e0       = 0;
    int  done_cnt = 0;
    int  d0_g     = 0;
    int  busy_end = 0;
    bit  run_active = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Buffer: address registered, then data registered (rdata valid 2 cycles after request).
    always @(posedge clk) begin
        a0_d   <= raddr0;
        a1_d   <= raddr1;
        rdata0 <= mem[a0_d];
        rdata1 <= mem[a1_d];
    end

    // Monitor: pops the scoreboard whenever the DUT reads or writes.
    always @(posedge clk) begin : mon
        int  rel;
        rd_t r;
        wr_t w;
        #1;
        edge_cnt++;
        rel = edge_cnt - e0;
        if (run_active) check("busy", 64'(busy), 64'(rel >= 1 && rel <= busy_end));
        if (read_valid) begin
            if (rq.size() == 0) check("spurious_rd", 1, 0);
            else begin
                r = rq.pop_front();
                check("raddr0", 64'(raddr0), 64'(r.a0));
                check("raddr1", 64'(raddr1), 64'(r.a1));
                check("rd_cyc", 64'(rel), 64'(r.cyc));
            end
        end
        if (wren) begin
            if (wq.size() == 0) check("spurious_wr", 1, 0);
            else begin
                w = wq.pop_front();
                check("waddr", 64'(waddr), 64'(w.addr));
                check("wdata", 64'(wdata), 64'(w.data));
                check("wr_cyc", 64'(rel), 64'(w.cyc));
                check("wr_done", 64'(done), 64'(w.dn));
            end
        end else if (done) begin
            check("done_no_wr", 1, 0);
        end
        if (done) done_cnt++;
    end

    task automatic run_op(input int src, input int n, input int dst);
        int h, hl;
        logic [31:0] lo, hi;
        logic [32:0] s;
        logic c;
        h  = (n + 1) / 2;
        hl = n / 2;
        c  = 1'b0;
        for (int i = 0; i < h; i++) begin
            rq.push_back('{(src + i) % BS, (src + h + i) % BS, 1 + i});
            lo = mem[(src + i) % BS];
            hi = (i < hl) ? mem[(src + h + i) % BS] : 32'h0;
            s  = {1'b0, lo} + {1'b0, hi} + 33'(c);
            wq.push_back('{(dst + i) % BS, s[31:0], 1 + LAT + i, 1'b0});
            c = s[32];
        end
        wq.push_back('{(dst + h) % BS, {31'b0, c}, h + LAT + 1, 1'b1});
        @(negedge clk);
        e0         = edge_cnt;
        busy_end   = h + LAT + 1;
        d0_g       = done_cnt;
        run_active = 1'b1;
        src_pos    = AW'(src);
        src_size   = AW'(n);
        dst_pos    = AW'(dst);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input int exp_res);
        for (int k = 0; k < 200 && done_cnt == d0_g; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        run_active = 1'b0;
        check("done_count", 64'(done_cnt - d0_g), 1);
        check("wq_empty", 64'(wq.size()), 0);
        check("rq_empty", 64'(rq.size()), 0);
        check("res_size", 64'(res_size), 64'(exp_res));
        wq.delete();
        rq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < BS; i++) mem[i] = $urandom;
        rstn = 1'b1; start = 1'b0; src_pos = '0; src_size = '0; dst_pos = '0;
        #3 rstn = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_wren", 64'(wren), 0);
        check("rst_res_size", 64'(res_size), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Even size
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        run_op(0, 4, 16);
        finish_op(3);

        // Odd size with garbage on the nonexistent hi limb
        mem[32] = 10; mem[33] = 20; mem[34] = 30; mem[35] = 40; mem[36] = 50; mem[37] = 32'hDEADBEEF;
        run_op(32, 5, 48);
        finish_op(4);

        // Carry ripple
        mem[0] = 32'hFFFFFFFF; mem[1] = 32'hFFFFFFFF; mem[2] = 1; mem[3] = 0;
        run_op(0, 4, 16);
        finish_op(3);

        // Read address wrap
        mem[254] = 32'h11; mem[255] = 32'h22; mem[0] = 32'h33; mem[1] = 32'h44;
        run_op(254, 4, 16);
        finish_op(3);

        // Write address wrap
        mem[0] = 32'h80000000; mem[1] = 5; mem[2] = 32'h80000000; mem[3] = 7;
        run_op(0, 4, 255);
        finish_op(3);

        // Start while busy is ignored
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        run_op(0, 4, 16);
        src_size = AW'(8);
        dst_pos  = AW'(80);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(3);
        repeat (12) @(negedge clk);

        // Reset mid-operation
        for (int i = 0; i < 6; i++) mem[64 + i] = 32'h1000 + 32'(i);
        run_op(64, 6, 128);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        run_active = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_done", 64'(done), 0);
        check("mid_rst_rv", 64'(read_valid), 0);
        check("mid_rst_raddr0", 64'(raddr0), 0);
        check("mid_rst_raddr1", 64'(raddr1), 0);
        check("mid_rst_wren", 64'(wren), 0);
        check("mid_rst_waddr", 64'(waddr), 0);
        check("mid_rst_wdata", 64'(wdata), 0);
        check("mid_rst_res_size", 64'(res_size), 0);
        wq.delete();
        rq.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        mem[0] = 9; mem[1] = 8; mem[2] = 7; mem[3] = 6;
        run_op(0, 4, 16);
        finish_op(3);

        // Random sizes
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(2, 20);
            for (int i = 0; i < 22; i++) mem[100 + i] = (t[0]) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15)) : $urandom;
            run_op(100, n, 200);
            finish_op((n + 1) / 2 + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
